// File: rtl/rtc_reg_scheduler_pkg.sv
// Shared definitions for the RTC register scheduler: register indices, address map,
// edit groups, FSM state encoding and the bus timeout default.
package rtc_reg_scheduler_pkg;

  localparam int unsigned NumRegs           = 9;
  localparam int unsigned GroupLen          = 3;
  localparam int unsigned TimeoutCycDefault = 255;

  typedef logic [3:0]         idx_t;
  typedef logic [NumRegs-1:0] reg_mask_t;

  localparam idx_t IdxSegHora   = 4'd0;
  localparam idx_t IdxMinHora   = 4'd1;
  localparam idx_t IdxHoraHora  = 4'd2;
  localparam idx_t IdxDia       = 4'd3;
  localparam idx_t IdxMes       = 4'd4;
  localparam idx_t IdxJahr      = 4'd5;
  localparam idx_t IdxSegTimer  = 4'd6;
  localparam idx_t IdxMinTimer  = 4'd7;
  localparam idx_t IdxHoraTimer = 4'd8;

  // First index of each edit group; every group spans GroupLen consecutive indices.
  localparam idx_t HoraFirst  = IdxSegHora;
  localparam idx_t FechaFirst = IdxDia;
  localparam idx_t TimerFirst = IdxSegTimer;

  typedef enum logic [1:0] {
    FieldHora  = 2'd0,
    FieldFecha = 2'd1,
    FieldTimer = 2'd2,
    FieldNone  = 2'd3
  } field_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdReq  = 3'd1,
    StRdLoad = 3'd2,
    StWrReq  = 3'd3,
    StWrNext = 3'd4
  } state_e;

  function automatic logic [7:0] reg_addr(idx_t idx);
    logic [7:0] addr;
    case (idx)
      IdxSegHora:   addr = 8'h21;
      IdxMinHora:   addr = 8'h22;
      IdxHoraHora:  addr = 8'h23;
      IdxDia:       addr = 8'h24;
      IdxMes:       addr = 8'h25;
      IdxJahr:      addr = 8'h26;
      IdxSegTimer:  addr = 8'h41;
      IdxMinTimer:  addr = 8'h42;
      IdxHoraTimer: addr = 8'h43;
      default:      addr = 8'h00;
    endcase
    return addr;
  endfunction

  function automatic idx_t group_first(logic [1:0] field);
    idx_t first;
    case (field)
      FieldFecha: first = FechaFirst;
      FieldTimer: first = TimerFirst;
      default:    first = HoraFirst;
    endcase
    return first;
  endfunction

  function automatic reg_mask_t group_mask(logic edit_mode, logic [1:0] field);
    reg_mask_t mask;
    mask = '0;
    if (edit_mode && (field != FieldNone)) begin
      mask = reg_mask_t'(9'b000000111) << group_first(field);
    end
    return mask;
  endfunction

endpackage

// File: rtl/rtc_reg_scheduler_if.sv
// RTC bus handshake: the scheduler is master, the RTC register block is slave.
interface rtc_reg_scheduler_if;
  logic       bus_req;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic       bus_ack;

  modport master (output bus_req, output bus_wr, output bus_addr, input bus_ack);
  modport slave  (input bus_req, input bus_wr, input bus_addr, output bus_ack);
endinterface

// File: rtl/bus_timeout_counter.sv
// Counts cycles of an outstanding bus request; expired flags the last allowed cycle.
module bus_timeout_counter #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] LastCount = 8'(Limit - 1);

  logic [7:0] count_q;

  // Expires on the edge that would end the Limit-th cycle of the request.
  assign expired = start && (count_q == LastCount);

  // Cycle counter, cleared whenever no request is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (start && !expired) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/rtc_reg_scheduler.sv
// Schedules RTC register read sweeps and group writes over a req/ack bus, with
// per-group freeze while editing and a bounded wait on each bus transaction.
module rtc_reg_scheduler
  import rtc_reg_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                refresh_tick,
  input  logic                edit_mode,
  input  logic [1:0]          edit_field,
  input  logic                commit,
  rtc_reg_scheduler_if.master bus,
  output logic [NumRegs-1:0]  cs,
  output logic [NumRegs-1:0]  hold,
  output logic                busy,
  output logic                sweep_done,
  output logic                bus_err
);

  state_e    state_q;
  idx_t      idx_q;
  idx_t      wr_last_q;
  logic      refresh_pend_q;
  logic      commit_pend_q;
  logic      req_q;
  logic      wr_q;
  logic [7:0] addr_q;
  reg_mask_t cs_q;
  reg_mask_t hold_q;
  logic      busy_q;
  logic      done_q;
  logic      err_q;

  logic      first_found;
  idx_t      first_idx;
  logic      next_found;
  idx_t      next_idx;
  logic      take_commit;
  logic      start_write;
  logic      take_refresh;
  logic      in_req;
  logic      expired;

  assign bus.bus_req  = req_q;
  assign bus.bus_wr   = wr_q;
  assign bus.bus_addr = addr_q;
  assign cs           = cs_q;
  assign hold         = hold_q;
  assign busy         = busy_q;
  assign sweep_done   = done_q;
  assign bus_err      = err_q;

  // IDLE acts only on registered pending flags, so a request lands one edge after it is seen.
  // A commit for group "none" is consumed here and lets a pending refresh start instead.
  assign take_commit  = (state_q == StIdle) && commit_pend_q;
  assign start_write  = take_commit && (edit_field != FieldNone);
  assign take_refresh = (state_q == StIdle) && refresh_pend_q && !start_write;
  assign in_req       = (state_q == StRdReq) || (state_q == StWrReq);

  // Lowest non-held index overall and lowest non-held index above the current one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NumRegs - 1; i >= 0; i--) begin
      if (!hold_q[i]) begin
        first_found = 1'b1;
        first_idx   = idx_t'(i);
        if (i > int'(idx_q)) begin
          next_found = 1'b1;
          next_idx   = idx_t'(i);
        end
      end
    end
  end

  bus_timeout_counter #(
    .Limit(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .start  (in_req),
    .clear  (!in_req),
    .expired(expired)
  );

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      wr_last_q      <= '0;
      refresh_pend_q <= 1'b0;
      commit_pend_q  <= 1'b0;
      req_q          <= 1'b0;
      wr_q           <= 1'b0;
      addr_q         <= 8'h00;
      cs_q           <= '0;
      hold_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      refresh_pend_q <= (refresh_pend_q | refresh_tick) & ~take_refresh;
      commit_pend_q  <= (commit_pend_q | commit) & ~take_commit;
      hold_q         <= group_mask(edit_mode, edit_field);
      cs_q           <= '0;
      done_q         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_write) begin
            state_q   <= StWrReq;
            idx_q     <= group_first(edit_field);
            wr_last_q <= group_first(edit_field) + idx_t'(GroupLen - 1);
            req_q     <= 1'b1;
            wr_q      <= 1'b1;
            addr_q    <= reg_addr(group_first(edit_field));
            busy_q    <= 1'b1;
          end else if (take_refresh) begin
            if (first_found) begin
              state_q <= StRdReq;
              idx_q   <= first_idx;
              req_q   <= 1'b1;
              wr_q    <= 1'b0;
              addr_q  <= reg_addr(first_idx);
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRdReq: begin
          if (bus.bus_ack || expired) begin
            state_q <= StRdLoad;
            req_q   <= 1'b0;
            addr_q  <= 8'h00;
            if (bus.bus_ack) begin
              cs_q <= reg_mask_t'(1) << idx_q;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StRdLoad: begin
          if (next_found) begin
            state_q <= StRdReq;
            idx_q   <= next_idx;
            req_q   <= 1'b1;
            addr_q  <= reg_addr(next_idx);
          end else begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StWrReq: begin
          if (bus.bus_ack || expired) begin
            state_q <= StWrNext;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            if (!bus.bus_ack) begin
              err_q <= 1'b1;
            end
          end
        end
        StWrNext: begin
          if (idx_q == wr_last_q) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StWrReq;
            idx_q   <= idx_q + 4'd1;
            req_q   <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= reg_addr(idx_q + 4'd1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_reg_scheduler.sv
// Self-checking bench for rtc_reg_scheduler: an RTC responder, a transaction monitor and a
// transaction-level reference model of sweeps and group writes.
module tb_rtc_reg_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       refresh_tick;
  logic       edit_mode;
  logic [1:0] edit_field;
  logic       commit;
  logic [8:0] cs;
  logic [8:0] hold;
  logic       busy;
  logic       sweep_done;
  logic       bus_err;
  logic       resp_ack;
  logic       stray_ack;

  rtc_reg_scheduler_if bif();
  assign bif.bus_ack = resp_ack | stray_ack;

  rtc_reg_scheduler #(
    .TIMEOUT_CYC(255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .refresh_tick(refresh_tick),
    .edit_mode   (edit_mode),
    .edit_field  (edit_field),
    .commit      (commit),
    .bus         (bif),
    .cs          (cs),
    .hold        (hold),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Responder settings.
  int         resp_lat  = 2;
  bit         resp_rand = 1'b0;
  logic [7:0] withhold  = 8'h00;

  // Observed and expected transaction logs: {wr, addr} per bus request, cs value per pulse.
  logic [8:0] bus_log[$];
  logic [8:0] cs_log[$];
  int         len_log[$];
  int         done_cnt;
  logic [8:0] exp_bus[$];
  logic [8:0] exp_cs[$];
  int         exp_done;

  typedef struct {
    logic       mode;
    logic [1:0] field;
    logic [8:0] exp_hold;
  } hold_vec_t;

  hold_vec_t hv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RTC responder: acks each request resp_lat cycles after it is seen, never for withhold.
  initial begin
    int cnt = 0;
    int lat = 2;
    resp_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
        cnt      = 0;
      end else if (bif.bus_req) begin
        if (cnt == 0) lat = resp_rand ? int'($urandom_range(1, 4)) : resp_lat;
        cnt++;
        if (cnt >= lat && bif.bus_addr != withhold) resp_ack = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: logs bus requests, request lengths, cs pulses and sweep_done pulses.
  initial begin
    logic prev_req = 1'b0;
    int   len      = 0;
    forever begin
      @(negedge clk);
      if (bif.bus_req && !prev_req) bus_log.push_back({bif.bus_wr, bif.bus_addr});
      if (bif.bus_req) begin
        len++;
      end else if (prev_req) begin
        len_log.push_back(len);
        len = 0;
      end
      if (cs != 9'h000) begin
        cs_log.push_back(cs);
        check("cs_onehot_no_req", 32'({$countones(cs) == 1, bif.bus_req}), 32'b10);
      end
      if (sweep_done) done_cnt++;
      prev_req = bif.bus_req;
    end
  end

  function automatic logic [7:0] model_addr(int i);
    logic [7:0] a;
    if (i < 6) a = 8'h21 + 8'(i);
    else       a = 8'h41 + 8'(i - 6);
    return a;
  endfunction

  function automatic logic [8:0] model_hold(logic m, logic [1:0] f);
    logic [8:0] h;
    h = 9'h000;
    if (m && f != 2'd3) h = 9'(9'b111 << (3 * int'(f)));
    return h;
  endfunction

  // One sweep: every non-held register read in order; skip_cs marks a timed-out index.
  task automatic model_sweep(input logic [8:0] held, input int skip_cs);
    for (int i = 0; i < 9; i++) begin
      if (!held[i]) begin
        exp_bus.push_back({1'b0, model_addr(i)});
        if (i != skip_cs) exp_cs.push_back(9'(9'b1 << i));
      end
    end
    exp_done++;
  endtask

  task automatic model_write(input logic [1:0] f);
    if (f != 2'd3) begin
      for (int k = 0; k < 3; k++) exp_bus.push_back({1'b1, model_addr(3 * int'(f) + k)});
    end
  endtask

  task automatic clear_logs();
    bus_log.delete();
    cs_log.delete();
    len_log.delete();
    done_cnt = 0;
    exp_bus.delete();
    exp_cs.delete();
    exp_done = 0;
  endtask

  task automatic check_logs(input string name);
    int n;
    int bad;
    checks++;
    n   = (bus_log.size() < exp_bus.size()) ? bus_log.size() : exp_bus.size();
    bad = -1;
    for (int i = 0; i < n; i++) if (bad < 0 && bus_log[i] !== exp_bus[i]) bad = i;
    if (bad < 0 && bus_log.size() != exp_bus.size()) bad = n;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s bus_log: got %0d txns required %0d, first difference at entry %0d (got 0x%0h required 0x%0h)",
               name, bus_log.size(), exp_bus.size(), bad,
               (bad < bus_log.size()) ? bus_log[bad] : 9'h000,
               (bad < exp_bus.size()) ? exp_bus[bad] : 9'h000);
    end
    checks++;
    n   = (cs_log.size() < exp_cs.size()) ? cs_log.size() : exp_cs.size();
    bad = -1;
    for (int i = 0; i < n; i++) if (bad < 0 && cs_log[i] !== exp_cs[i]) bad = i;
    if (bad < 0 && cs_log.size() != exp_cs.size()) bad = n;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s cs_log: got %0d pulses required %0d, first difference at entry %0d (got 0x%0h required 0x%0h)",
               name, cs_log.size(), exp_cs.size(), bad,
               (bad < cs_log.size()) ? cs_log[bad] : 9'h000,
               (bad < exp_cs.size()) ? exp_cs[bad] : 9'h000);
    end
    check({name, "_sweep_done_count"}, 32'(done_cnt), 32'(exp_done));
  endtask

  // Waits until busy has stayed low for 4 cycles, within a cycle budget.
  task automatic wait_idle(input string name, input int budget);
    int quiet = 0;
    int n     = 0;
    while (quiet < 4 && n < budget) begin
      step();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    checks++;
    if (quiet < 4) begin
      failures++;
      $display("FAIL %s idle_wait: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic pulse_tick();
    refresh_tick = 1'b1;
    step();
    refresh_tick = 1'b0;
  endtask

  initial begin
    int         hits;
    logic       m;
    logic [1:0] f;
    logic [1:0] op;

    reset        = 1'b1;
    refresh_tick = 1'b0;
    edit_mode    = 1'b1;
    edit_field   = 2'd0;
    commit       = 1'b0;
    stray_ack    = 1'b0;
    clear_logs();
    repeat (3) step();

    // Reset state, with an edit selection present that must not reach hold.
    check("rst_bus_req",    32'(bif.bus_req),  32'd0);
    check("rst_bus_wr",     32'(bif.bus_wr),   32'd0);
    check("rst_bus_addr",   32'(bif.bus_addr), 32'h00);
    check("rst_cs",         32'(cs),           32'h000);
    check("rst_hold",       32'(hold),         32'h000);
    check("rst_busy",       32'(busy),         32'd0);
    check("rst_sweep_done", 32'(sweep_done),   32'd0);
    check("rst_bus_err",    32'(bus_err),      32'd0);

    reset     = 1'b0;
    edit_mode = 1'b0;
    step();

    // Hold decode table.
    hv[0] = '{1'b0, 2'd0, 9'h000};
    hv[1] = '{1'b0, 2'd3, 9'h000};
    hv[2] = '{1'b1, 2'd0, 9'h007};
    hv[3] = '{1'b1, 2'd1, 9'h038};
    hv[4] = '{1'b1, 2'd2, 9'h1C0};
    hv[5] = '{1'b1, 2'd3, 9'h000};
    hv[6] = '{1'b0, 2'd2, 9'h000};
    hv[7] = '{1'b1, 2'd1, 9'h038};
    for (int i = 0; i < 8; i++) begin
      edit_mode  = hv[i].mode;
      edit_field = hv[i].field;
      step();
      check($sformatf("hold_vec%0d", i), 32'(hold), 32'(hv[i].exp_hold));
      check($sformatf("hold_vec%0d_busy", i), 32'(busy), 32'd0);
    end

    // Full refresh sweep with cycle-exact latency, load pulse and gap checks.
    edit_mode = 1'b0;
    step();
    clear_logs();
    model_sweep(9'h000, -1);
    pulse_tick();
    check("lat_not_early", 32'(bif.bus_req), 32'd0);
    step();
    check("lat_req",  32'(bif.bus_req),  32'd1);
    check("lat_addr", 32'(bif.bus_addr), 32'h21);
    check("lat_wr",   32'(bif.bus_wr),   32'd0);
    step();
    step();
    check("load_req_low", 32'(bif.bus_req), 32'd0);
    check("load_cs0",     32'(cs),          32'h001);
    step();
    check("gap_req",  32'(bif.bus_req),  32'd1);
    check("gap_addr", 32'(bif.bus_addr), 32'h22);
    check("gap_cs",   32'(cs),           32'h000);
    wait_idle("sweep", 300);
    check_logs("sweep");

    // Fecha group frozen: its registers are skipped.
    edit_mode  = 1'b1;
    edit_field = 2'd1;
    step();
    check("skip_hold", 32'(hold), 32'h038);
    clear_logs();
    model_sweep(9'h038, -1);
    pulse_tick();
    wait_idle("skip", 300);
    check_logs("skip");
    hits = 0;
    foreach (bus_log[i]) if (bus_log[i][7:0] >= 8'h24 && bus_log[i][7:0] <= 8'h26) hits++;
    check("skip_fecha_hits", 32'(hits), 32'd0);

    // Commit and refresh together: timer writes first, then the full sweep.
    edit_mode  = 1'b0;
    edit_field = 2'd2;
    step();
    clear_logs();
    model_write(2'd2);
    model_sweep(9'h000, -1);
    refresh_tick = 1'b1;
    commit       = 1'b1;
    step();
    refresh_tick = 1'b0;
    commit       = 1'b0;
    step();
    check("arb_first_wr",   32'(bif.bus_wr),   32'd1);
    check("arb_first_addr", 32'(bif.bus_addr), 32'h41);
    wait_idle("arb", 400);
    check_logs("arb");

    // Timeout at 0x22.
    withhold = 8'h22;
    clear_logs();
    model_sweep(9'h000, 1);
    pulse_tick();
    wait_idle("timeout", 1000);
    check_logs("timeout");
    check("timeout_len", 32'((len_log.size() > 1) ? len_log[1] : -1), 32'd255);
    check("timeout_err", 32'(bus_err), 32'd1);
    withhold = 8'h00;

    // Reset while waiting on 0x24, then restart.
    withhold = 8'h24;
    clear_logs();
    pulse_tick();
    begin
      int n = 0;
      while (!(bif.bus_req && bif.bus_addr == 8'h24) && n < 100) begin
        step();
        n++;
      end
    end
    check("reach_0x24", 32'(bif.bus_req && bif.bus_addr == 8'h24), 32'd1);
    repeat (3) step();
    edit_mode = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_req",  32'(bif.bus_req),  32'd0);
    check("mid_rst_addr", 32'(bif.bus_addr), 32'h00);
    check("mid_rst_busy", 32'(busy),         32'd0);
    check("mid_rst_hold", 32'(hold),         32'h000);
    check("mid_rst_err",  32'(bus_err),      32'd0);
    step();
    edit_mode = 1'b0;
    withhold  = 8'h00;
    reset     = 1'b0;
    clear_logs();
    repeat (5) step();
    check("post_rst_cs",   32'(cs_log.size()),  32'd0);
    check("post_rst_bus",  32'(bus_log.size()), 32'd0);
    check("post_rst_busy", 32'(busy),           32'd0);
    model_sweep(9'h000, -1);
    pulse_tick();
    wait_idle("restart", 300);
    check_logs("restart");

    // Three ticks during a sweep collapse into one further sweep.
    clear_logs();
    model_sweep(9'h000, -1);
    model_sweep(9'h000, -1);
    pulse_tick();
    repeat (3) begin
      repeat (5) step();
      pulse_tick();
    end
    wait_idle("collapse", 600);
    check_logs("collapse");

    // Commit with no group selected is dropped.
    edit_field = 2'd3;
    clear_logs();
    commit = 1'b1;
    step();
    commit = 1'b0;
    wait_idle("commit_none", 50);
    check_logs("commit_none");

    // edit_field changing after the write has started does not redirect it.
    edit_field = 2'd0;
    clear_logs();
    model_write(2'd0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    edit_field = 2'd2;
    wait_idle("field_change", 100);
    check_logs("field_change");

    // Stray ack while idle is ignored.
    clear_logs();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_cs",   32'(cs_log.size()),  32'd0);
    check("stray_bus",  32'(bus_log.size()), 32'd0);

    // Randomised edit settings, request mix and ack latency against the model.
    resp_rand = 1'b1;
    for (int it = 0; it < 20; it++) begin
      m          = 1'($urandom_range(0, 1));
      f          = 2'($urandom_range(0, 3));
      op         = 2'($urandom_range(1, 3));
      edit_mode  = m;
      edit_field = f;
      step();
      step();
      clear_logs();
      if (op[1]) model_write(f);
      if (op[0]) model_sweep(model_hold(m, f), -1);
      commit       = op[1];
      refresh_tick = op[0];
      step();
      commit       = 1'b0;
      refresh_tick = 1'b0;
      wait_idle($sformatf("rand%0d", it), 400);
      check_logs($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_reg_scheduler.md
RTC_REG_SCHEDULER -- requirements
Module: rtc_reg_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: max cycles bus_req waits for bus_ack before abort.
REQ-002 clk  in  1  system clock; every state element updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 refresh_tick  in  1  one-cycle request for a full RTC read sweep.
REQ-005 edit_mode  in  1  user is editing; the group selected by edit_field is frozen.
REQ-006 edit_field  in  2  group select: 0=hora, 1=fecha, 2=timer, 3=none.
REQ-007 commit  in  1  one-cycle request to write the selected group's counter values to the RTC.
REQ-008 bus_ack  in  1  RTC bus transaction complete.
REQ-009 bus_req  out  1  RTC bus transaction request.
REQ-010 bus_wr  out  1  1=write, 0=read; valid while bus_req=1.
REQ-011 bus_addr  out  8  RTC register address; valid while bus_req=1.
REQ-012 cs  out  9  one-hot register load select, index order: 0 seg_hora, 1 min_hora, 2 hora_hora, 3 dia, 4 mes, 5 jahr, 6 seg_timer, 7 min_timer, 8 hora_timer.
REQ-013 hold  out  9  per-register hold, same index order as cs.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 sweep_done  out  1  one-cycle pulse when a read sweep completes.
REQ-016 bus_err  out  1  sticky timeout flag.

Function
REQ-017 Address map: idx0..8 -> 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43.
REQ-018 States: IDLE, RD_REQ, RD_LOAD, WR_REQ, WR_NEXT; all outputs are registered.
REQ-019 refresh_tick and commit each set a pending flag; repeated pulses while already pending collapse into one request.
REQ-020 Arbitration in IDLE: a pending commit wins over a pending refresh; the loser stays pending and is serviced next.
REQ-021 Latency: a request sampled at edge N in IDLE drives bus_req=1 from edge N+1.
REQ-022 RD_REQ: bus_req=1, bus_wr=0, bus_addr=map[idx]; held until bus_ack is sampled.
REQ-023 On bus_ack in RD_REQ, next cycle: bus_req=0, cs[idx]=1 for exactly one cycle (RD_LOAD). Then idx advances and the next RD_REQ starts, giving a one-cycle gap.
REQ-024 During a sweep, indices whose hold bit is 1 are skipped: no bus cycle and no cs pulse.
REQ-025 After idx 8, or the last non-held index, return to IDLE and pulse sweep_done for one cycle. A sweep with all indices held pulses sweep_done one cycle after start, with no bus activity.
REQ-026 hold[i]=1 iff edit_mode=1 and i belongs to the group selected by edit_field (hora 0-2, fecha 3-5, timer 6-8); hold is updated every cycle.
REQ-027 Write sequence for the selected group, three registers in ascending idx: bus_req=1, bus_wr=1, bus_addr=map[idx] until bus_ack, then one idle cycle (WR_NEXT). No cs pulses are issued during writes.
REQ-028 A commit with edit_field=3 is discarded without a bus cycle.
REQ-029 edit_field is sampled once, at commit start; later changes do not affect the write in progress.
REQ-030 Timeout: if bus_req stays high for TIMEOUT_CYC cycles without bus_ack, drop bus_req, set bus_err, skip that idx (no cs pulse) and continue the sequence.
REQ-031 bus_ack sampled outside RD_REQ/WR_REQ is ignored.

Reset
REQ-032 Reset forces IDLE and clears idx, both pending flags, the timeout counter and bus_err; all outputs go to 0 (bus_addr=0x00, cs=0, hold=0).
REQ-033 Reset asserted mid-transaction aborts it immediately; no cs pulse follows the deassertion of reset.
REQ-034 bus_err is cleared only by reset.

Structure
REQ-035 A shared package holds the address map, the register index constants, the group-to-index ranges, the state encoding and the TIMEOUT_CYC default.
REQ-036 The timeout counter is one sub-module, bus_timeout_counter (start/clear/expired, 8-bit).

Verification
REQ-037 Refresh sweep: refresh_tick, with bus_ack returned 2 cycles after each bus_req -> addresses 0x21..0x26, 0x41..0x43 in order, each cs bit pulses once, then sweep_done.
REQ-038 Hold skip: edit_mode=1, edit_field=1, refresh_tick -> hold=0x038, six reads only, and no activity on 0x24-0x26.
REQ-039 Arbitration: commit and refresh_tick in the same cycle with edit_field=2 -> writes to 0x41, 0x42, 0x43 with bus_wr=1 first, then the full read sweep.
REQ-040 Timeout: bus_ack withheld at 0x22 -> bus_req drops after 255 cycles, bus_err=1, cs[1] never pulses, sweep continues at 0x23.
REQ-041 Reset mid-read: reset while waiting on 0x24 -> all outputs 0 and busy=0; a new refresh_tick restarts at 0x21.
REQ-042 Collapse: three refresh_ticks during one sweep -> exactly one additional sweep follows.
